// File: rtl/cache_coherence_pkg.sv
// Shared coherence types: bus snoop ops, MESI line states and the
// snoop responder FSM states, plus the MESI snoop next-state function.
package cache_coherence_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_BUSRD   = 2'b01,
        OP_BUSUPGR = 2'b10,
        OP_BUSRDX  = 2'b11
    } bus_op_t;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        SNP_IDLE    = 2'b00,
        SNP_LOOKUP  = 2'b01,
        SNP_RESPOND = 2'b10
    } snoop_state_t;

    // New local state after another agent's op is observed on the bus.
    function automatic mesi_t mesi_snoop_next(input bus_op_t op,
                                              input mesi_t cur);
        mesi_t nxt;
        nxt = cur;
        case (op)
            OP_BUSRD:              if (cur != MESI_I) nxt = MESI_S;
            OP_BUSUPGR, OP_BUSRDX: nxt = MESI_I;
            default:               nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/snoop_responder.sv
// Snoop responder: looks up snooped bus ops in the local L1 array,
// supplies data, downgrades MESI state and flags illegal upgrades.
module snoop_responder
    import cache_coherence_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            bus_operation_in,
    input  logic [31:0]           bus_address_in,
    output logic [31:0]           bus_data_out,
    output logic                  cache_hit_out,
    output logic                  dirty_out,
    output logic                  snoop_busy,
    output logic                  arr_rd_en,
    output logic [INDEX_BITS-1:0] arr_index,
    input  logic [TAG_BITS-1:0]   arr_tag_in,
    input  logic [1:0]            arr_state_in,
    input  logic [31:0]           arr_data_in,
    output logic                  arr_wr_en,
    output logic [1:0]            arr_state_out,
    output logic                  protocol_err
);

    snoop_state_t          state;
    logic                  armed;
    bus_op_t               op_q;
    logic [TAG_BITS-1:0]   tag_q;
    logic [INDEX_BITS-1:0] idx_q;
    logic                  wr_q;

    bus_op_t op_in;
    logic    accept;
    mesi_t   cur_state;
    mesi_t   nxt_state;
    logic    hit;
    logic    supply;
    logic    illegal;
    logic    unused_addr;

    assign op_in       = bus_op_t'(bus_operation_in);
    assign unused_addr = ^bus_address_in[1:0];

    // Accept a fresh op only from IDLE; a held op needs a NONE to re-arm.
    assign accept = !reset && (state == SNP_IDLE)
                  && (op_in != OP_NONE) && armed;

    assign arr_rd_en  = accept;
    assign arr_index  = accept ? bus_address_in[INDEX_BITS+1:2] : idx_q;
    assign snoop_busy = accept || (!reset && state != SNP_IDLE);
    // Reset in RESPOND must not let the state write reach the array.
    assign arr_wr_en  = wr_q && !reset;

    // Decode the array read returned during LOOKUP.
    always_comb begin
        cur_state = mesi_t'(arr_state_in);
        hit       = (arr_tag_in == tag_q) && (cur_state != MESI_I);
        nxt_state = mesi_snoop_next(op_q, cur_state);
        supply    = hit && !(op_q == OP_BUSUPGR && cur_state == MESI_S);
        illegal   = hit && (op_q == OP_BUSUPGR) && (cur_state != MESI_S);
    end

    // Snoop FSM with one-cycle registered response pulse in RESPOND.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SNP_IDLE;
            armed         <= 1'b1;
            op_q          <= OP_NONE;
            tag_q         <= '0;
            idx_q         <= '0;
            wr_q          <= 1'b0;
            cache_hit_out <= 1'b0;
            dirty_out     <= 1'b0;
            bus_data_out  <= 32'h0;
            arr_state_out <= 2'b00;
            protocol_err  <= 1'b0;
        end else begin
            wr_q          <= 1'b0;
            cache_hit_out <= 1'b0;
            dirty_out     <= 1'b0;
            bus_data_out  <= 32'h0;
            arr_state_out <= 2'b00;
            if (op_in == OP_NONE) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end
            case (state)
                SNP_IDLE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        tag_q <= bus_address_in[31:INDEX_BITS+2];
                        idx_q <= bus_address_in[INDEX_BITS+1:2];
                        state <= SNP_LOOKUP;
                    end
                end
                SNP_LOOKUP: begin
                    cache_hit_out <= hit;
                    dirty_out     <= supply && (cur_state == MESI_M);
                    bus_data_out  <= supply ? arr_data_in : 32'h0;
                    wr_q          <= hit && (nxt_state != cur_state);
                    arr_state_out <= hit ? nxt_state : MESI_I;
                    if (illegal) protocol_err <= 1'b1;
                    state         <= SNP_RESPOND;
                end
                SNP_RESPOND: state <= SNP_IDLE;
                default:     state <= SNP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: directed MESI scenarios
// plus random snoops against a table-driven reference model.
module tb_snoop_responder;
    import cache_coherence_pkg::*;

    localparam int IB = 6;
    localparam int TB = 30 - IB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    bus_op = 2'b00;
    logic [31:0]   bus_addr = 32'h0;
    logic [31:0]   bus_data_out;
    logic          cache_hit_out;
    logic          dirty_out;
    logic          snoop_busy;
    logic          arr_rd_en;
    logic [IB-1:0] arr_index;
    logic [TB-1:0] arr_tag_in = '0;
    logic [1:0]    arr_state_in = 2'b00;
    logic [31:0]   arr_data_in = 32'h0;
    logic          arr_wr_en;
    logic [1:0]    arr_state_out;
    logic          protocol_err;

    snoop_responder #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
        .clk(clk), .reset(reset),
        .bus_operation_in(bus_op), .bus_address_in(bus_addr),
        .bus_data_out(bus_data_out), .cache_hit_out(cache_hit_out),
        .dirty_out(dirty_out), .snoop_busy(snoop_busy),
        .arr_rd_en(arr_rd_en), .arr_index(arr_index),
        .arr_tag_in(arr_tag_in), .arr_state_in(arr_state_in),
        .arr_data_in(arr_data_in), .arr_wr_en(arr_wr_en),
        .arr_state_out(arr_state_out), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic exp_err = 1'b0;

    logic [TB-1:0] m_tag[64];
    logic [1:0]    m_state[64];
    logic [31:0]   m_data[64];

    // Array model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (arr_rd_en) begin
            arr_tag_in   <= m_tag[arr_index];
            arr_state_in <= m_state[arr_index];
            arr_data_in  <= m_data[arr_index];
        end
    end

    function automatic logic [31:0] mk(input logic [TB-1:0] t, input int i);
        logic [IB-1:0] ix;
        ix = IB'(i);
        return {t, ix, 2'b00};
    endfunction

    // One complete snoop transaction checked against the MESI rule table.
    task automatic snoop(input logic [1:0] op, input logic [31:0] addr,
                         input string nm);
        int idx;
        logic [TB-1:0] tg;
        logic [1:0] cur, nxt, e_st;
        logic e_hit, e_sup, e_dirty, e_wr;
        logic [31:0] e_data;
        idx = int'(addr[IB+1:2]);
        tg = addr[31:IB+2];
        cur = m_state[idx];
        e_hit = (m_tag[idx] == tg) && (cur != 2'b00);
        nxt = (op == 2'b01) ? 2'b01 : 2'b00;
        e_sup = e_hit && !(op == 2'b10 && cur == 2'b01);
        e_data = e_sup ? m_data[idx] : 32'h0;
        e_dirty = e_sup && (cur == 2'b11);
        e_wr = e_hit && (nxt != cur);
        e_st = e_hit ? nxt : 2'b00;
        if (e_hit && op == 2'b10 && cur != 2'b01) exp_err = 1'b1;

        @(negedge clk); bus_op = op; bus_addr = addr; #1;
        n_checks++; if (arr_rd_en !== 1'b1) begin n_fail++; $display("FAIL %s rd_en got=%0b exp=1", nm, arr_rd_en); end
        n_checks++; if (arr_index !== IB'(idx)) begin n_fail++; $display("FAIL %s index got=%0d exp=%0d", nm, arr_index, idx); end
        n_checks++; if (snoop_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy0 got=%0b exp=1", nm, snoop_busy); end

        @(negedge clk); bus_op = 2'b00; #1;
        n_checks++; if (snoop_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy1 got=%0b exp=1", nm, snoop_busy); end
        n_checks++; if (cache_hit_out !== 1'b0 || arr_wr_en !== 1'b0) begin n_fail++; $display("FAIL %s early resp hit=%0b wr=%0b exp=0", nm, cache_hit_out, arr_wr_en); end

        @(negedge clk); #1;
        n_checks++; if (snoop_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy2 got=%0b exp=1", nm, snoop_busy); end
        n_checks++; if (cache_hit_out !== e_hit) begin n_fail++; $display("FAIL %s hit got=%0b exp=%0b", nm, cache_hit_out, e_hit); end
        n_checks++; if (dirty_out !== e_dirty) begin n_fail++; $display("FAIL %s dirty got=%0b exp=%0b", nm, dirty_out, e_dirty); end
        n_checks++; if (bus_data_out !== e_data) begin n_fail++; $display("FAIL %s data got=%h exp=%h", nm, bus_data_out, e_data); end
        n_checks++; if (arr_wr_en !== e_wr) begin n_fail++; $display("FAIL %s wr_en got=%0b exp=%0b", nm, arr_wr_en, e_wr); end
        n_checks++; if (arr_state_out !== e_st) begin n_fail++; $display("FAIL %s new_state got=%0d exp=%0d", nm, arr_state_out, e_st); end
        n_checks++; if (protocol_err !== exp_err) begin n_fail++; $display("FAIL %s perr got=%0b exp=%0b", nm, protocol_err, exp_err); end
        if (e_wr) begin
            n_checks++; if (arr_index !== IB'(idx)) begin n_fail++; $display("FAIL %s wr index got=%0d exp=%0d", nm, arr_index, idx); end
        end

        @(negedge clk); #1;
        n_checks++; if (snoop_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy3 got=%0b exp=0", nm, snoop_busy); end
        n_checks++; if ({cache_hit_out, dirty_out, arr_wr_en} !== 3'b000 || bus_data_out !== 32'h0) begin n_fail++; $display("FAIL %s resp not cleared hit=%0b dirty=%0b wr=%0b data=%h exp=0", nm, cache_hit_out, dirty_out, arr_wr_en, bus_data_out); end
        if (e_hit) m_state[idx] = nxt;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_op = 2'b01; bus_addr = 32'h0000_0014;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (arr_rd_en !== 1'b0 || snoop_busy !== 1'b0) begin n_fail++; $display("FAIL reset accept rd=%0b busy=%0b exp=0", arr_rd_en, snoop_busy); end
        bus_op = 2'b00; reset = 1'b0; exp_err = 1'b0;
        @(negedge clk); #1;
        n_checks++; if ({cache_hit_out, dirty_out, arr_wr_en, protocol_err, snoop_busy, arr_rd_en} !== 6'b0) begin n_fail++; $display("FAIL reset flags got=%b exp=000000", {cache_hit_out, dirty_out, arr_wr_en, protocol_err, snoop_busy, arr_rd_en}); end
        n_checks++; if (bus_data_out !== 32'h0 || arr_state_out !== 2'b00) begin n_fail++; $display("FAIL reset data got=%h st=%0d exp=0", bus_data_out, arr_state_out); end
    endtask

    task automatic test_busrd_m();
        m_tag[5] = 24'h12_3456; m_state[5] = 2'b11; m_data[5] = 32'hDEAD_BEEF;
        snoop(2'b01, mk(24'h12_3456, 5), "busrd_m");
    endtask

    task automatic test_busrdx_e_and_i();
        m_tag[7] = 24'h00_0A0B; m_state[7] = 2'b10; m_data[7] = 32'hCAFE_F00D;
        snoop(2'b11, mk(24'h00_0A0B, 7), "busrdx_e");
        snoop(2'b11, mk(24'h00_0A0B, 7), "busrdx_i");
    endtask

    task automatic test_tag_miss();
        m_tag[20] = 24'hAB_CDEF; m_state[20] = 2'b11; m_data[20] = 32'h1234_5678;
        snoop(2'b11, mk(24'hAB_CDEE, 20), "tag_miss");
        snoop(2'b01, mk(24'hAB_CDEF, 20), "after_miss");
    endtask

    task automatic test_back_to_back();
        m_tag[1] = 24'h00_0001; m_state[1] = 2'b01; m_data[1] = 32'h1111_1111;
        m_tag[2] = 24'h00_0002; m_state[2] = 2'b10; m_data[2] = 32'h2222_2222;
        snoop(2'b01, mk(24'h00_0001, 1), "b2b_a");
        snoop(2'b01, mk(24'h00_0002, 2), "b2b_b");
    endtask

    task automatic test_held_upgr();
        int accepts, hits;
        accepts = 0; hits = 0;
        m_tag[9] = 24'h55_AA55; m_state[9] = 2'b01; m_data[9] = 32'h9999_0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); bus_op = 2'b10; bus_addr = mk(24'h55_AA55, 9); #1;
            if (arr_rd_en === 1'b1) accepts++;
            if (cache_hit_out === 1'b1) hits++;
        end
        n_checks++; if (accepts != 1) begin n_fail++; $display("FAIL held accepts got=%0d exp=1", accepts); end
        n_checks++; if (hits != 1) begin n_fail++; $display("FAIL held responses got=%0d exp=1", hits); end
        m_state[9] = 2'b00;
        @(negedge clk); bus_op = 2'b00;
        @(negedge clk); bus_op = 2'b10; #1;
        n_checks++; if (arr_rd_en !== 1'b1) begin n_fail++; $display("FAIL held rearm got=%0b exp=1", arr_rd_en); end
        @(negedge clk); bus_op = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_upgr_m_sticky();
        m_tag[30] = 24'h0F_F0F0; m_state[30] = 2'b11; m_data[30] = 32'hBADC_0DE5;
        snoop(2'b10, mk(24'h0F_F0F0, 30), "upgr_m");
        m_tag[31] = 24'h00_1234; m_state[31] = 2'b10; m_data[31] = 32'h3131_3131;
        snoop(2'b01, mk(24'h00_1234, 31), "sticky_rd");
        snoop(2'b11, mk(24'h00_1234, 31), "sticky_rdx");
    endtask

    task automatic test_random();
        int idx;
        logic [1:0] op;
        logic [TB-1:0] tg;
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 7) + 40;
            if ($urandom_range(0, 2) == 0) begin
                m_state[idx] = 2'($urandom_range(0, 3));
                m_data[idx] = $urandom;
            end
            op = 2'($urandom_range(1, 3));
            tg = ($urandom_range(0, 3) != 0) ? m_tag[idx] : TB'($urandom);
            snoop(op, mk(tg, idx), "random");
        end
    endtask

    task automatic test_reset_mid(input bit in_respond);
        m_tag[12] = 24'h77_7777; m_state[12] = 2'b11; m_data[12] = 32'hFEED_FACE;
        @(negedge clk); bus_op = 2'b11; bus_addr = mk(24'h77_7777, 12);
        @(negedge clk); bus_op = 2'b00;
        if (!in_respond) reset = 1'b1;
        @(negedge clk);
        if (in_respond) begin
            reset = 1'b1; #1;
            n_checks++; if (arr_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_respond wr_en got=%0b exp=0", arr_wr_en); end
            @(negedge clk);
        end
        reset = 1'b0; exp_err = 1'b0; #1;
        n_checks++; if ({cache_hit_out, dirty_out, arr_wr_en, protocol_err, snoop_busy} !== 5'b0) begin n_fail++; $display("FAIL rst_mid%0d flags got=%b exp=00000", in_respond, {cache_hit_out, dirty_out, arr_wr_en, protocol_err, snoop_busy}); end
        n_checks++; if (bus_data_out !== 32'h0 || arr_state_out !== 2'b00) begin n_fail++; $display("FAIL rst_mid%0d data got=%h st=%0d exp=0", in_respond, bus_data_out, arr_state_out); end
        @(negedge clk); #1;
        n_checks++; if (cache_hit_out !== 1'b0 || arr_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid%0d late resp hit=%0b wr=%0b exp=0", in_respond, cache_hit_out, arr_wr_en); end
        snoop(2'b01, mk(24'h77_7777, 12), "post_reset");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_tag[i] = TB'($urandom);
            m_state[i] = 2'b00;
            m_data[i] = $urandom;
        end
        test_reset();
        test_busrd_m();
        test_busrdx_e_and_i();
        test_tag_miss();
        test_back_to_back();
        test_held_upgr();
        test_upgr_m_sticky();
        test_random();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 Parameter INDEX_BITS, default 6, number of L1 set-index bits (direct-mapped, one 32-bit word per line).
REQ-002 Parameter TAG_BITS, default 30-INDEX_BITS, tag width taken from bus_address_in[31:INDEX_BITS+2].
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bus_operation_in  input  2  snooped op from bus_controller: 00 NONE, 01 BusRd, 10 BusUpgr, 11 BusRdX.
REQ-006 bus_address_in  input  32  word address of snooped op.
REQ-007 bus_data_out  output  32  supplied line data toward bus_controller.
REQ-008 cache_hit_out  output  1  local valid copy found (snoop hit).
REQ-009 dirty_out  output  1  supplied data was Modified; bus_controller forwards it to L2.
REQ-010 snoop_busy  output  1  stalls the local core's L1 array access.
REQ-011 arr_rd_en  output  1  array read strobe.
REQ-012 arr_index  output  INDEX_BITS  array set index.
REQ-013 arr_tag_in  input  TAG_BITS  stored tag, valid one cycle after arr_rd_en.
REQ-014 arr_state_in  input  2  stored MESI state, same timing.
REQ-015 arr_data_in  input  32  stored data word, same timing.
REQ-016 arr_wr_en  output  1  MESI state write strobe (state field only).
REQ-017 arr_state_out  output  2  new MESI state for arr_index.
REQ-018 protocol_err  output  1  sticky flag for an illegal snoop.

Function
REQ-019 MESI encoding SHALL be I=00, S=01, E=10, M=11.
REQ-020 FSM SHALL have states IDLE, LOOKUP, RESPOND; IDLE->LOOKUP on accepted op, LOOKUP->RESPOND unconditionally, RESPOND->IDLE unconditionally.
REQ-021 In IDLE, an op SHALL be accepted when bus_operation_in != NONE and armed=1; op, tag, and index are captured; armed is cleared.
REQ-022 armed SHALL be set whenever bus_operation_in == NONE is sampled, so a held op counts as one transaction.
REQ-023 arr_rd_en SHALL be high in the accept cycle (combinational), with arr_index = bus_address_in[INDEX_BITS+1:2].
REQ-024 snoop_busy SHALL be high combinationally in the accept cycle and registered high during LOOKUP and RESPOND.
REQ-025 In LOOKUP, hit = (arr_tag_in == captured tag) && arr_state_in != I; results SHALL be registered into RESPOND.
REQ-026 BusRd hit: S/E/M->S; supply data; dirty_out=1 only if M.
REQ-027 BusRdX hit: S/E/M->I; supply data; dirty_out=1 only if M.
REQ-028 BusUpgr hit in S: ->I, no data supplied. BusUpgr hit in E or M: ->I, set protocol_err, supply data with dirty_out=1 if M.
REQ-029 On a miss, no state write SHALL occur, and cache_hit_out, dirty_out, and bus_data_out SHALL all be 0.
REQ-030 In RESPOND, cache_hit_out, dirty_out, bus_data_out, arr_wr_en, and arr_state_out SHALL be valid for exactly one cycle; they are 0 in every other state.
REQ-031 Latency: accept at cycle 0, response at cycle 2, IDLE at cycle 3; any op present in LOOKUP or RESPOND is not accepted.
REQ-032 arr_wr_en SHALL be asserted only on a hit whose next state differs from the current state.

Reset
REQ-033 Reset SHALL force IDLE, armed=1, protocol_err=0, and all outputs to 0, overriding any in-flight transaction.
REQ-034 Reset asserted in RESPOND SHALL suppress arr_wr_en in that cycle.
REQ-035 protocol_err SHALL clear only on reset.

Structure
REQ-036 Package cache_coherence_pkg SHALL hold bus_op_t, mesi_t, snoop_state_t and the op/MESI encodings; bus_controller and the L1 controller import it.
REQ-037 The block SHALL be a single module with no sub-modules; the MESI next-state function SHALL be a package function, mesi_snoop_next.

Verification
REQ-038 Line idx 5 in M with data 0xDEADBEEF, BusRd to the same address -> cycle 2: cache_hit_out=1, dirty_out=1, bus_data_out=0xDEADBEEF, arr_state_out=S.
REQ-039 Line in E, BusRdX -> hit=1, dirty_out=0, data supplied, arr_state_out=I; line in I -> all responses 0 and no arr_wr_en.
REQ-040 Tag mismatch on a valid M line -> miss, no write, and snoop_busy high for exactly 3 cycles.
REQ-041 BusUpgr held for 6 cycles -> exactly one response; re-accept only after one NONE cycle.
REQ-042 BusUpgr to an M line -> protocol_err=1, and it stays set through later legal ops until reset.
REQ-043 Reset in LOOKUP and in RESPOND -> next cycle IDLE, no arr_wr_en, all outputs 0.
